gpio_ctrl: RTL and testbench

Parametrised GPIO controller: the next generation of the single-width GPIO register block. It adds configurable pin count, an input synchroniser with an optional debounce filter, and rising, falling and both-edge interrupt modes. It also adds atomic set/clear of output bits and a registered read port. It sits on the same simple register bus (we/addr/dat) between the system interconnect and the pad ring, one instance per GPIO bank.

---
 rtl/gpio_ctrl_pkg.sv | 35 +++
 rtl/gpio_ctrl_in_filter.sv | 58 +++++
 rtl/gpio_ctrl.sv | 115 +++++++++++
 tb/tb_gpio_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: register word offsets, CTRL bit positions and edge-mode helpers for gpio_ctrl
package gpio_ctrl_pkg;

   localparam logic [3:0] ADDR_IN       = 4'h0;
   localparam logic [3:0] ADDR_OUT      = 4'h1;
   localparam logic [3:0] ADDR_OE       = 4'h2;
   localparam logic [3:0] ADDR_INTE     = 4'h3;
   localparam logic [3:0] ADDR_PTRIG    = 4'h4;
   localparam logic [3:0] ADDR_AUX      = 4'h5;
   localparam logic [3:0] ADDR_CTRL     = 4'h6;
   localparam logic [3:0] ADDR_INTS     = 4'h7;
   localparam logic [3:0] ADDR_BOTH     = 4'h8;
   localparam logic [3:0] ADDR_OUT_SET  = 4'h9;
   localparam logic [3:0] ADDR_OUT_CLR  = 4'hA;
   localparam logic [3:0] ADDR_DEBOUNCE = 4'hB;

   localparam int CTRL_GIE  = 0;
   localparam int CTRL_ECLK = 1;
   localparam int CTRL_PEND = 2;

   typedef enum logic [1:0] {
      EDGE_FALL = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_BOTH = 2'd2
   } edge_mode_e;

   function automatic edge_mode_e edge_mode(input logic both, input logic ptrig);
      return both ? EDGE_BOTH : ptrig ? EDGE_RISE : EDGE_FALL;
   endfunction

   function automatic logic edge_hit(input edge_mode_e m, input logic cur, input logic prev);
      return (m == EDGE_BOTH) ? (cur ^ prev) : (m == EDGE_RISE) ? (cur & ~prev) : (~cur & prev);
   endfunction

endpackage

// File: rtl/gpio_ctrl_in_filter.sv
// gpio_in_filter: pad synchroniser, optional ECLK capture and tick-based debounce producing the filtered input vector
module gpio_in_filter #(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic              sysclk,
   input  logic              sysrst,
   input  logic [GPIO_W-1:0] pad_i,
   input  logic              eclk_i,
   input  logic              eclk_mode,
   input  logic [DB_W-1:0]   db_period,
   input  logic              db_restart,
   output logic [GPIO_W-1:0] filt_o
);

   logic [GPIO_W:0]   sync_q [SYNC_STAGES];
   logic [GPIO_W-1:0] pads_s, hold_q, samp_q, cur, diff;
   logic [DB_W-1:0]   cnt_q;
   logic              eclk_s, eclk_prev, tick;

   assign {eclk_s, pads_s} = sync_q[SYNC_STAGES-1];
   assign cur  = eclk_mode ? hold_q : pads_s;
   assign tick = cnt_q == db_period;
   assign diff = cur ^ samp_q;

   // pads and the eclk strobe share one synchroniser chain
   always_ff @(posedge sysclk or negedge sysrst) begin
      if (!sysrst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {eclk_i, pad_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // eclk capture, shared prescaler and per-pin two-tick agreement filter
   always_ff @(posedge sysclk or negedge sysrst) begin
      if (!sysrst) begin
         eclk_prev <= 1'b0;
         hold_q    <= '0;
         samp_q    <= '0;
         cnt_q     <= '0;
         filt_o    <= '0;
      end else begin
         eclk_prev <= eclk_s;
         if (eclk_s && !eclk_prev) hold_q <= pads_s;
         cnt_q <= (db_restart || tick) ? '0 : cnt_q + 1'b1;
         if (db_period == '0) begin
            filt_o <= cur;
         end else if (tick) begin
            samp_q <= cur;
            filt_o <= (filt_o & diff) | (cur & ~diff);
         end
      end
   end

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO bank with register bus, atomic output ops, filtered inputs and edge interrupts
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int GPIO_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic              sysclk,
   input  logic              sysrst,
   input  logic              gpio_we,
   input  logic [31:0]       gpio_addr,
   input  logic [31:0]       gpio_dat_i,
   input  logic [GPIO_W-1:0] aux_i,
   input  logic [GPIO_W-1:0] in_pad_i,
   input  logic              gpio_eclk,
   output logic [31:0]       gpio_dat_o,
   output logic              gpio_inta_o,
   output logic [GPIO_W-1:0] out_pad_o,
   output logic [GPIO_W-1:0] oen_padoe_o
);

   logic [GPIO_W-1:0] out_q, oe_q, inte_q, ptrig_q, aux_q, both_q, ints_q;
   logic [GPIO_W-1:0] filt, filt_prev, hit, wdat, clr;
   logic [1:0]        ctrl_q;
   logic [DB_W-1:0]   db_q;
   logic [3:0]        word;
   logic [31:0]       rdata;
   logic              unused_bits;

   assign word        = gpio_addr[5:2];
   assign wdat        = gpio_dat_i[GPIO_W-1:0];
   assign clr         = (gpio_we && word == ADDR_INTS) ? wdat : '0;
   assign out_pad_o   = (aux_q & aux_i) | (~aux_q & out_q);
   assign oen_padoe_o = oe_q;
   assign unused_bits = ^{gpio_addr, gpio_dat_i};

   gpio_in_filter #(.GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) u_filter (
      .sysclk     (sysclk),
      .sysrst     (sysrst),
      .pad_i      (in_pad_i),
      .eclk_i     (gpio_eclk),
      .eclk_mode  (ctrl_q[CTRL_ECLK]),
      .db_period  (db_q),
      .db_restart (gpio_we && word == ADDR_DEBOUNCE),
      .filt_o     (filt)
   );

   // per-pin qualifying edge of the filtered input, gated by INTE
   always_comb begin
      hit = '0;
      for (int i = 0; i < GPIO_W; i++)
         hit[i] = inte_q[i] & edge_hit(edge_mode(both_q[i], ptrig_q[i]), filt[i], filt_prev[i]);
   end

   // read mux; write-only and unmapped words read as zero
   always_comb begin
      rdata = '0;
      case (word)
         ADDR_IN:       rdata = 32'(filt);
         ADDR_OUT:      rdata = 32'(out_q);
         ADDR_OE:       rdata = 32'(oe_q);
         ADDR_INTE:     rdata = 32'(inte_q);
         ADDR_PTRIG:    rdata = 32'(ptrig_q);
         ADDR_AUX:      rdata = 32'(aux_q);
         ADDR_CTRL: begin
            rdata = 32'(ctrl_q);
            rdata[CTRL_PEND] = |ints_q;
         end
         ADDR_INTS:     rdata = 32'(ints_q);
         ADDR_BOTH:     rdata = 32'(both_q);
         ADDR_DEBOUNCE: rdata = 32'(db_q);
         default:       rdata = '0;
      endcase
   end

   // register file, sticky status with set-over-clear, registered read and irq
   always_ff @(posedge sysclk or negedge sysrst) begin
      if (!sysrst) begin
         out_q       <= '0;
         oe_q        <= '0;
         inte_q      <= '0;
         ptrig_q     <= '0;
         aux_q       <= '0;
         both_q      <= '0;
         ints_q      <= '0;
         filt_prev   <= '0;
         ctrl_q      <= '0;
         db_q        <= '0;
         gpio_dat_o  <= '0;
         gpio_inta_o <= 1'b0;
      end else begin
         filt_prev   <= filt;
         ints_q      <= (ints_q & ~clr) | hit;
         gpio_inta_o <= ctrl_q[CTRL_GIE] & |ints_q;
         gpio_dat_o  <= rdata;
         if (gpio_we) begin
            case (word)
               ADDR_OUT:      out_q   <= wdat;
               ADDR_OE:       oe_q    <= wdat;
               ADDR_INTE:     inte_q  <= wdat;
               ADDR_PTRIG:    ptrig_q <= wdat;
               ADDR_AUX:      aux_q   <= wdat;
               ADDR_CTRL:     ctrl_q  <= gpio_dat_i[1:0];
               ADDR_BOTH:     both_q  <= wdat;
               ADDR_OUT_SET:  out_q   <= out_q | wdat;
               ADDR_OUT_CLR:  out_q   <= out_q & ~wdat;
               ADDR_DEBOUNCE: db_q    <= gpio_dat_i[DB_W-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: self-checking bench for gpio_ctrl (32-pin and 8-pin instances on a shared bus)
module tb_gpio_ctrl;

   localparam logic [31:0] A_IN = 32'h00, A_OUT = 32'h04, A_OE = 32'h08, A_INTE = 32'h0C;
   localparam logic [31:0] A_PTRIG = 32'h10, A_AUX = 32'h14, A_CTRL = 32'h18, A_INTS = 32'h1C;
   localparam logic [31:0] A_BOTH = 32'h20, A_SET = 32'h24, A_CLR = 32'h28, A_DB = 32'h2C;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
   } vec_t;

   logic        clk = 1'b0;
   logic        sysrst = 1'b0;
   logic        gpio_we = 1'b0;
   logic [31:0] gpio_addr = '0, gpio_dat_i = '0, aux_i = '0, in_pad_i = '0;
   logic        gpio_eclk = 1'b0;
   logic [31:0] gpio_dat_o, out_pad_o, oen_padoe_o, dat8;
   logic        gpio_inta_o, inta8;
   logic [7:0]  pad8, oen8;
   int          tests = 0, failed = 0;
   logic [31:0] m [16];
   vec_t        tbl [10];

   always #5 clk = ~clk;

   gpio_ctrl #(.GPIO_W(32), .SYNC_STAGES(2), .DB_W(16)) dut (
      .sysclk(clk), .sysrst(sysrst), .gpio_we(gpio_we), .gpio_addr(gpio_addr),
      .gpio_dat_i(gpio_dat_i), .aux_i(aux_i), .in_pad_i(in_pad_i), .gpio_eclk(gpio_eclk),
      .gpio_dat_o(gpio_dat_o), .gpio_inta_o(gpio_inta_o), .out_pad_o(out_pad_o),
      .oen_padoe_o(oen_padoe_o)
   );

   gpio_ctrl #(.GPIO_W(8), .SYNC_STAGES(2), .DB_W(16)) dut8 (
      .sysclk(clk), .sysrst(sysrst), .gpio_we(gpio_we), .gpio_addr(gpio_addr),
      .gpio_dat_i(gpio_dat_i), .aux_i(aux_i[7:0]), .in_pad_i(in_pad_i[7:0]), .gpio_eclk(gpio_eclk),
      .gpio_dat_o(dat8), .gpio_inta_o(inta8), .out_pad_o(pad8), .oen_padoe_o(oen8)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      gpio_we = 1'b1; gpio_addr = a; gpio_dat_i = d;
      tick(1);
      gpio_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      gpio_addr = a;
      tick(1);
   endtask

   // reference register file: word index -> value, with the bank's access rules
   function automatic logic [31:0] model_rd(input int w);
      case (w)
         1, 2, 3, 4, 5, 7, 8, 11: return m[w];
         6: return m[6] | ((m[7] != 0) ? 32'h4 : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_wr(input int w, input logic [31:0] d);
      case (w)
         1, 2, 3, 4, 5, 8: m[w] = d;
         6:  m[6] = d & 32'h3;
         7:  m[7] = m[7] & ~d;
         9:  m[1] = m[1] | d;
         10: m[1] = m[1] & ~d;
         11: m[11] = d & 32'hFFFF;
         default: ;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic bad;
      tbl[0] = '{"tbl_out",    A_OUT,        32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[1] = '{"tbl_oe",     A_OE,         32'hFFFFFFFF, 32'hFFFFFFFF};
      tbl[2] = '{"tbl_inte",   A_INTE,       32'h000000FF, 32'h000000FF};
      tbl[3] = '{"tbl_ptrig",  A_PTRIG,      32'h000000FF, 32'h000000FF};
      tbl[4] = '{"tbl_ctrl",   A_CTRL,       32'hFFFFFFF9, 32'h00000001};
      tbl[5] = '{"tbl_db",     A_DB,         32'hABCD0000, 32'h00000000};
      tbl[6] = '{"tbl_set_ro", A_SET,        32'h0000FFFF, 32'h00000000};
      tbl[7] = '{"tbl_unmap",  32'h3C,       32'hFFFFFFFF, 32'h00000000};
      tbl[8] = '{"tbl_in_ro",  A_IN,         32'hFFFFFFFF, 32'h00000000};
      tbl[9] = '{"tbl_ints",   A_INTS,       32'hFFFFFFFF, 32'h00000000};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_dat", gpio_dat_o, 0);
      chk("rst_inta", 32'(gpio_inta_o), 0);
      chk("rst_pad", out_pad_o, 0);
      chk("rst_oen", oen_padoe_o, 0);
      sysrst = 1'b1;
      tick(2);
      chk("first_edges_inta", 32'(gpio_inta_o), 0);

      wr(A_OUT, 32'hA5A5A5A5);
      chk("out_pad", out_pad_o, 32'hA5A5A5A5);
      wr(A_OE, 32'hFFFFFFFF);
      chk("oen_pad", oen_padoe_o, 32'hFFFFFFFF);
      rd(A_OUT);
      chk("out_readback", gpio_dat_o, 32'hA5A5A5A5);

      foreach (tbl[i]) begin
         wr(tbl[i].addr, tbl[i].wdata);
         rd(tbl[i].addr);
         chk(tbl[i].name, gpio_dat_o, tbl[i].rexp);
      end
      chk("out_after_set", out_pad_o, 32'hA5A5FFFF);

      // mid-run reset with a pending interrupt
      in_pad_i = 32'h0F;
      tick(6);
      chk("pre_reset_inta", 32'(gpio_inta_o), 1);
      sysrst = 1'b0;
      in_pad_i = '0;
      #2;
      chk("midrst_dat", gpio_dat_o, 0);
      chk("midrst_inta", 32'(gpio_inta_o), 0);
      chk("midrst_pad", out_pad_o, 0);
      chk("midrst_oen", oen_padoe_o, 0);
      tick(1);
      sysrst = 1'b1;
      for (int a = 0; a < 12; a++) begin
         rd(32'(a) << 2);
         chk($sformatf("midrst_reg%0d", a), gpio_dat_o, 0);
      end

      // atomic set/clear
      wr(A_OUT, 32'h0000FF00);
      wr(A_SET, 32'h0000000F);
      wr(A_CLR, 32'h00000F00);
      rd(A_OUT);
      chk("atomic_out", gpio_dat_o, 32'h0000F00F);
      chk("atomic_pad", out_pad_o, 32'h0000F00F);

      // pad-to-IN latency, bypass
      gpio_addr = A_IN;
      in_pad_i = 32'h12345678;
      tick(3);
      chk("lat_early", gpio_dat_o, 0);
      tick(1);
      chk("lat_in", gpio_dat_o, 32'h12345678);
      in_pad_i = '0;
      tick(6);

      // interrupts: rising
      wr(A_INTE, 32'hFF);
      wr(A_PTRIG, 32'hFF);
      wr(A_CTRL, 32'h1);
      gpio_addr = A_INTS;
      in_pad_i = 32'hF0;
      tick(4);
      chk("inta_early", 32'(gpio_inta_o), 0);
      tick(1);
      chk("inta_set", 32'(gpio_inta_o), 1);
      chk("ints_rise", gpio_dat_o, 32'hF0);
      rd(A_CTRL);
      chk("ctrl_pending", gpio_dat_o, 32'h5);
      wr(A_INTS, 32'h30);
      rd(A_INTS);
      chk("ints_w1c", gpio_dat_o, 32'hC0);
      wr(A_INTS, 32'hFF);
      in_pad_i = '0;
      tick(6);
      rd(A_INTS);
      chk("ints_fall_ignored", gpio_dat_o, 0);
      chk("inta_cleared", 32'(gpio_inta_o), 0);

      // both-edge on pin 0
      wr(A_BOTH, 32'h1);
      in_pad_i = 32'h1;
      tick(6);
      rd(A_INTS);
      chk("both_rise", gpio_dat_o, 32'h1);
      wr(A_INTS, 32'h1);
      rd(A_INTS);
      chk("both_clr", gpio_dat_o, 0);
      in_pad_i = 32'h0;
      tick(6);
      rd(A_INTS);
      chk("both_fall", gpio_dat_o, 32'h1);
      wr(A_INTS, 32'hFF);

      // edge and W1C of the same bit on the same edge
      in_pad_i = 32'h2;
      tick(3);
      wr(A_INTS, 32'h2);
      rd(A_INTS);
      chk("set_wins", gpio_dat_o, 32'h2);
      in_pad_i = '0;
      tick(6);
      wr(A_INTS, 32'hFF);
      tick(2);

      // debounce: glitch rejected, level accepted
      wr(A_DB, 32'd9);
      gpio_addr = A_IN;
      tick(3);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         in_pad_i = (i < 5) ? 32'h8 : 32'h0;
         tick(1);
         if (gpio_dat_o[3] !== 1'b0 || gpio_inta_o !== 1'b0) bad = 1'b1;
      end
      chk("db_glitch", 32'(bad), 0);
      rd(A_INTS);
      chk("db_glitch_ints", gpio_dat_o, 0);
      gpio_addr = A_IN;
      in_pad_i = 32'h8;
      n = 0;
      while (n < 40) begin
         tick(1);
         n++;
         if (gpio_dat_o[3] === 1'b1) break;
      end
      if (n > 30) $display("FAIL db_level_time: took %0d cycles, limit 30", n);
      chk("db_level", 32'(n <= 30), 1);
      rd(A_INTS);
      chk("db_level_ints", gpio_dat_o, 32'h8);

      // narrow instance
      wr(A_OUT, 32'hFFFFFFFF);
      rd(A_OUT);
      chk("w8_out", dat8, 32'h000000FF);
      chk("w8_pad", 32'(pad8), 32'hFF);
      rd(32'h3C);
      chk("w8_unmapped", dat8, 0);

      // randomized register traffic against the reference register file
      sysrst = 1'b0;
      in_pad_i = '0;
      tick(1);
      sysrst = 1'b1;
      foreach (m[i]) m[i] = '0;
      for (int k = 0; k < 300; k++) begin
         int w;
         logic [31:0] d, exp_rd;
         w = $urandom_range(0, 15);
         d = $urandom;
         gpio_we = 1'($urandom_range(0, 1));
         gpio_addr = ($urandom & 32'hFFFFFFC3) | (32'(w) << 2);
         gpio_dat_i = d;
         aux_i = $urandom;
         exp_rd = model_rd(w);
         if (gpio_we) model_wr(w, d);
         tick(1);
         chk("rnd_read", gpio_dat_o, exp_rd);
         chk("rnd_pad", out_pad_o, (m[5] & aux_i) | (~m[5] & m[1]));
         chk("rnd_oen", oen_padoe_o, m[2]);
      end
      gpio_we = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
